decode_pipe: RTL and testbench

Pipelined RISC-V instruction decode stage sitting between fetch and register-read/execute. Each cycle it accepts one 32-bit instruction and its PC over a valid/ready handshake. It produces register indices, a fully formed sign-extended immediate (I/S/B/U/J formats, XLEN wide), function bits, an extended control vector and an illegal-instruction flag. The result is registered, buffered by a 2-entry skid buffer for full throughput under backpressure, and the stage keeps saturating decode statistics.

---
 rtl/decode_pipe.sv | 180 ++++++++++++++++++
 tb/tb_decode_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// RISC-V decode stage: combinational decode of the incoming word, a registered
// output slot plus one skid entry for backpressure, and saturating statistics.
module decode_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [9:0]       out_func,
    output logic [9:0]       out_ctrl,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_Z = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [9:0]      func;
        logic [9:0]      ctrl;
        logic            illegal;
    } entry_t;

    logic [2:0]  w_imm_sel;
    logic [9:0]  w_ctrl;
    logic        w_illegal;
    logic [31:0] w_imm32;
    entry_t      w_dec;
    logic        w_accept;
    logic        w_out_fire;

    entry_t           r_out;
    entry_t           r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    // Every listed opcode ends in 2'b11, so a bad quadrant lands in default.
    always_comb begin
        w_ctrl    = 10'h000;
        w_imm_sel = IMM_Z;
        w_illegal = 1'b0;
        case (in_instr[6:0])
            OP_R:      w_ctrl = 10'h001;
            OP_I:      begin w_ctrl = 10'h009; w_imm_sel = IMM_I; end
            OP_LOAD:   begin w_ctrl = 10'h00D; w_imm_sel = IMM_I; end
            OP_STORE:  begin w_ctrl = 10'h00A; w_imm_sel = IMM_S; end
            OP_BRANCH: begin w_ctrl = 10'h028; w_imm_sel = IMM_B; end
            OP_JAL:    begin w_ctrl = 10'h019; w_imm_sel = IMM_J; end
            OP_JALR:   begin w_ctrl = 10'h119; w_imm_sel = IMM_I; end
            OP_LUI:    begin w_ctrl = 10'h089; w_imm_sel = IMM_U; end
            OP_AUIPC:  begin w_ctrl = 10'h049; w_imm_sel = IMM_U; end
            OP_MISC:   w_ctrl = 10'h200;
            OP_SYSTEM: w_ctrl = 10'h200;
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_imm32 = 32'h0;
        case (w_imm_sel)
            IMM_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            IMM_U: w_imm32 = {in_instr[31:12], 12'h000};
            IMM_J: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            default: w_imm32 = 32'h0;
        endcase
    end

    always_comb begin
        w_dec.pc      = in_pc;
        w_dec.rd      = w_ctrl[0] ? in_instr[11:7] : 5'd0;
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.imm     = XLEN'($signed(w_imm32));
        w_dec.func    = {in_instr[31:25], in_instr[14:12]};
        w_dec.ctrl    = w_ctrl;
        w_dec.illegal = w_illegal;
    end

    assign in_ready   = !r_skid_valid && !reset;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_out_fire = r_out_valid && out_ready;

    // The output slot refills whenever it is empty or draining; the skid entry
    // only catches an accept that arrives while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid <= w_dec;
                end
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (!flush && w_out_fire) begin
            if (r_dec_cnt != {CNT_W{1'b1}}) begin
                r_dec_cnt <= r_dec_cnt + 1'b1;
            end
            if (r_out.illegal && (r_ill_cnt != {CNT_W{1'b1}})) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out.pc;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_imm     = r_out.imm;
    assign out_func    = r_out.func;
    assign out_ctrl    = r_out.ctrl;
    assign out_illegal = r_out.illegal;
    assign dec_count   = r_dec_cnt;
    assign ill_count   = r_ill_cnt;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: a driver pushes expected decodes from a
// reference model, a monitor compares whatever the stage presents.
module tb_decode_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [9:0]  func;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [9:0]  out_func, out_ctrl;
    logic        out_illegal;
    logic [15:0] dec_count, ill_count;

    logic        reset64 = 1'b1;
    logic        flush64 = 1'b0;
    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_instr64 = 32'h0;
    logic [63:0] in_pc64 = 64'h0;
    logic        out_valid64;
    logic        out_ready64 = 1'b0;
    logic [63:0] out_pc64;
    logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
    logic [63:0] out_imm64;
    logic [9:0]  out_func64, out_ctrl64;
    logic        out_illegal64;
    logic [1:0]  dec_count64, ill_count64;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   exp_dec = 0;
    int   exp_ill = 0;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_func(out_func), .out_ctrl(out_ctrl), .out_illegal(out_illegal),
        .dec_count(dec_count), .ill_count(ill_count)
    );

    decode_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .reset(reset64), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64),
        .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_imm(out_imm64),
        .out_func(out_func64), .out_ctrl(out_ctrl64), .out_illegal(out_illegal64),
        .dec_count(dec_count64), .ill_count(ill_count64)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference decode built from the field definitions using integer arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   s;
        s      = ins;
        e.pc   = pc;
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.func = {ins[31:25], ins[14:12]};
        e.ill  = 1'b0;
        e.imm  = 32'h0;
        case (ins[6:0])
            7'h33: e.ctrl = 10'h001;
            7'h13: begin e.ctrl = 10'h009; e.imm = s >>> 20; end
            7'h03: begin e.ctrl = 10'h00D; e.imm = s >>> 20; end
            7'h67: begin e.ctrl = 10'h119; e.imm = s >>> 20; end
            7'h23: begin e.ctrl = 10'h00A; e.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin
                e.ctrl = 10'h028;
                e.imm  = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                         + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                e.ctrl = 10'h019;
                e.imm  = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096
                         + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            7'h37: begin e.ctrl = 10'h089; e.imm = ins & 32'hFFFFF000; end
            7'h17: begin e.ctrl = 10'h049; e.imm = ins & 32'hFFFFF000; end
            7'h0F, 7'h73: e.ctrl = 10'h200;
            default: begin e.ctrl = 10'h000; e.ill = 1'b1; end
        endcase
        e.rd = e.ctrl[0] ? ins[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 13);
        w = $urandom;
        if (k < 11) begin
            w[6:0] = ops[k];
        end
        return w;
    endfunction

    // One cycle of stimulus: inputs change after the edge, acceptance is judged
    // mid-cycle when in_ready is settled.
    task automatic step(input logic rs, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic rdy, input logic fl,
                        output logic acc);
        @(posedge clk);
        #2;
        reset = rs; flush = fl; in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy;
        @(negedge clk);
        #2;
        acc = v && in_ready && !fl && !rs;
        if (acc) begin
            q.push_back(model(ins, pc));
        end
    endtask

    task automatic do_reset();
        logic a;
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
        chk("reset_data", {out_pc, out_imm, out_ctrl, out_rd, out_illegal}, 128'h0);
    endtask

    // Monitor: the queue mirrors what the DUT should be holding right now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                chk("in_ready_in_reset", in_ready, 1'b0);
                q.delete();
                exp_dec = 0;
                exp_ill = 0;
                continue;
            end
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (out_valid && q.size() > 0) begin
                chk("out_data", {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_func,
                                 out_ctrl, out_illegal}, q[0]);
            end
            chk("dec_count", dec_count, exp_dec[15:0]);
            chk("ill_count", ill_count, exp_ill[15:0]);
            if (flush) begin
                q.delete();
            end else if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                exp_dec++;
                if (e.ill) exp_ill++;
            end
        end
    end

    initial begin
        logic        a;
        logic        have;
        logic [31:0] cur_i, cur_pc;
        logic        v, rdy, fl, rs;

        // ADDI / BEQ / LUI
        do_reset();
        step(1'b0, 1'b1, 32'hFFF10093, 32'h100, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 32'hFE000EE3, 32'h104, 1'b1, 1'b0, a);
        chk("addi_fields", {out_rd, out_rs1, out_imm, out_ctrl, out_illegal, out_pc},
            {5'd1, 5'd2, 32'hFFFFFFFF, 10'h009, 1'b0, 32'h100});
        step(1'b0, 1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0, a);
        chk("beq_fields", {out_rd, out_imm, out_ctrl}, {5'd0, 32'hFFFFFFFC, 10'h028});
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        chk("lui_fields", {out_rd, out_imm, out_ctrl}, {5'd5, 32'h12345000, 10'h089});

        // Backpressure: A on output, B in skid, C held by fetch
        do_reset();
        step(1'b0, 1'b1, 32'h00A00093, 32'h200, 1'b0, 1'b0, a);
        step(1'b0, 1'b1, 32'h00B00113, 32'h204, 1'b0, 1'b0, a);
        step(1'b0, 1'b1, 32'h00C00193, 32'h208, 1'b0, 1'b0, a);
        chk("c_blocked", {in_ready, a, out_pc}, {1'b0, 1'b0, 32'h200});
        have = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, have, 32'h00C00193, 32'h208, 1'b1, 1'b0, a);
            if (a) have = 1'b0;
        end
        chk("abc_count", dec_count, 16'd3);

        // Illegal word followed by JAL
        do_reset();
        step(1'b0, 1'b1, 32'h00000000, 32'h300, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 32'h0000006F, 32'h304, 1'b1, 1'b0, a);
        chk("illegal_out", {out_illegal, out_ctrl, out_imm}, {1'b1, 10'h000, 32'h0});
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        chk("jal_out", {out_ctrl, ill_count}, {10'h019, 16'd1});

        // Flush with both entries full and a new input offered
        do_reset();
        step(1'b0, 1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0, a);
        step(1'b0, 1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0, a);
        step(1'b0, 1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1, a);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        chk("after_flush", {out_valid, in_ready, dec_count}, {1'b0, 1'b1, 16'd0});
        step(1'b0, 1'b1, 32'h00400093, 32'h40C, 1'b1, 1'b1, a);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        chk("flush_drops_input", out_valid, 1'b0);

        // Randomized traffic
        have = 1'b0;
        cur_i = 32'h0;
        cur_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                cur_i  = rand_instr();
                cur_pc = $urandom & 32'hFFFFFFFC;
            end
            v   = have || ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 39) == 0);
            rs  = ($urandom_range(0, 499) == 0);
            step(rs, v, cur_i, cur_pc, rdy, fl, a);
            have = v && !a && !fl && !rs;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        end

        // 64-bit datapath with 2-bit saturating counters
        @(posedge clk); #2;
        reset64 = 1'b1;
        @(posedge clk); #2;
        reset64 = 1'b0; in_valid64 = 1'b1; in_instr64 = 32'hFFF10093;
        in_pc64 = 64'h100; out_ready64 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            if (k == 0) begin
                chk("imm64", {out_valid64, out_imm64, out_pc64},
                    {1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h100});
            end
            if (k == 2) chk("cnt64_mid", dec_count64, 2'd2);
            if (k == 4) in_valid64 = 1'b0;
        end
        @(posedge clk); #2;
        chk("cnt64_sat", {out_valid64, dec_count64, ill_count64}, {1'b0, 2'd3, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
